// File: rtl/mult_pkg.sv
// Shared constants, FSM state and Booth recoding for the sequential signed multiplier.
// MULT_EARLY_ZERO_EN (optional) lets zero operands skip straight to completion.
package mult_pkg;

    localparam int MULT_W     = 32;
    localparam int MULT_STEPS = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_t;

    typedef enum logic [1:0] {
        NOP,
        ADD,
        SUB
    } booth_op_t;

    // Radix-2 Booth recoding of {Q[0], Q-1}
    function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
        case ({q0, q_m1})
            2'b01:   return ADD;
            2'b10:   return SUB;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/mult_unit_if.sv
// Control-unit <-> multiplier bus: start request, operands, product words and status.
interface mult_unit_if;

    logic                        mult_control;
    logic [mult_pkg::MULT_W-1:0] a_in;
    logic [mult_pkg::MULT_W-1:0] b_in;
    logic [mult_pkg::MULT_W-1:0] hi_out;
    logic [mult_pkg::MULT_W-1:0] lo_out;
    logic                        mult_end;
    logic                        busy;

    modport master (
        output mult_control, a_in, b_in,
        input  hi_out, lo_out, mult_end, busy
    );

    modport slave (
        input  mult_control, a_in, b_in,
        output hi_out, lo_out, mult_end, busy
    );

endinterface

// File: rtl/booth_step.sv
// One combinational Booth iteration: conditional add/sub of M, then arithmetic
// right shift of {acc, Q, Q-1}. Zero latency, no flow control.
module booth_step
    import mult_pkg::*;
(
    input  logic [MULT_W:0]   acc,
    input  logic [MULT_W:0]   m,
    input  logic [MULT_W-1:0] q,
    input  logic              q_m1,
    output logic [MULT_W:0]   acc_nxt,
    output logic [MULT_W-1:0] q_nxt,
    output logic              q_m1_nxt
);

    logic [MULT_W:0] sum;

    always_comb begin
        sum = acc;
        case (booth_decode(q[0], q_m1))
            ADD:     sum = acc + m;
            SUB:     sum = acc - m;
            default: sum = acc;
        endcase
        acc_nxt  = {sum[MULT_W], sum[MULT_W:1]};
        q_nxt    = {sum[0], q[MULT_W-1:1]};
        q_m1_nxt = q[0];
    end

endmodule

// File: rtl/mult_unit.sv
// Sequential 32x32 signed Booth multiplier; 33-cycle fixed latency start-to-mult_end.
// Starts are ignored while busy; MULT_EARLY_ZERO_EN finishes zero-operand starts in one cycle.
module mult_unit
    import mult_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    mult_unit_if.slave bus
);

    mult_state_t       state, state_nxt;
    logic [MULT_W:0]   acc, m;
    logic [MULT_W-1:0] q;
    logic              q_m1;
    logic [CNT_W-1:0]  cnt;
    logic [MULT_W-1:0] hi_q, lo_q;
    logic              start, zero_op, last_step;
    logic [MULT_W:0]   acc_step;
    logic [MULT_W-1:0] q_step;
    logic              q_m1_step;

    booth_step u_step (
        .acc      (acc),
        .m        (m),
        .q        (q),
        .q_m1     (q_m1),
        .acc_nxt  (acc_step),
        .q_nxt    (q_step),
        .q_m1_nxt (q_m1_step)
    );

    assign last_step = (cnt == CNT_W'(MULT_STEPS - 1));

`ifdef MULT_EARLY_ZERO_EN
    assign zero_op = (bus.a_in == '0) || (bus.b_in == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mult_control) begin
                    start     = 1'b1;
                    state_nxt = zero_op ? DONE : RUN;
                end
            end
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            m     <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                acc  <= '0;
                m    <= {bus.a_in[MULT_W-1], bus.a_in};
                q    <= bus.b_in;
                q_m1 <= 1'b0;
                cnt  <= '0;
                if (zero_op) begin
                    hi_q <= '0;
                    lo_q <= '0;
                end
            end else if (state == RUN) begin
                acc  <= acc_step;
                q    <= q_step;
                q_m1 <= q_m1_step;
                cnt  <= cnt + 1'b1;
                // Result words only move on the final step so HI/LO hold during RUN
                if (last_step) begin
                    hi_q <= acc_step[MULT_W-1:0];
                    lo_q <= q_step;
                end
            end
        end
    end

    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
    assign bus.mult_end = (state == DONE);
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_mult_unit.sv
// Directed self-checking bench for mult_unit: products, latency, busy window, ignore-while-busy, reset abort.
module tb_mult_unit;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    mult_unit_if u_if ();

    mult_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

`ifdef MULT_EARLY_ZERO_EN
    localparam int ZERO_LAT = 1;
    localparam int ZERO_BSY = 1;
`else
    localparam int ZERO_LAT = 33;
    localparam int ZERO_BSY = 33;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts an op from IDLE, waits for mult_end, returns latency (start edge = cycle T,
    // mult_end cycle counted as T+lat), busy cycles and the product, then steps back to IDLE.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bsy, output logic [63:0] prod);
        logic [63:0] prev;
        bit          moved;
        int          n;
        prev  = {u_if.hi_out, u_if.lo_out};
        moved = 1'b0;
        u_if.a_in         = a;
        u_if.b_in         = b;
        u_if.mult_control = 1'b1;
        @(posedge clk); #1;
        u_if.mult_control = 1'b0;
        n   = 0;
        bsy = 0;
        while (!u_if.mult_end && n < 100) begin
            if (u_if.busy) bsy++;
            if ({u_if.hi_out, u_if.lo_out} !== prev) moved = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (u_if.busy) bsy++;
        lat  = n + 1;
        prod = {u_if.hi_out, u_if.lo_out};
        check({tag, "_hold_during_run"}, 64'(moved), 64'd0);
        @(posedge clk); #1;
        check({tag, "_end_one_cycle"}, 64'(u_if.mult_end), 64'd0);
        check({tag, "_idle_after"}, 64'(u_if.busy), 64'd0);
    endtask

    initial begin
        int          lat, bsy, ends;
        logic [63:0] prod;

        n_total = 0;
        n_bad   = 0;
        clk     = 1'b0;
        reset   = 1'b1;
        u_if.mult_control = 1'b0;
        u_if.a_in = '0;
        u_if.b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi",   64'(u_if.hi_out),   64'd0);
        check("rst_lo",   64'(u_if.lo_out),   64'd0);
        check("rst_end",  64'(u_if.mult_end), 64'd0);
        check("rst_busy", 64'(u_if.busy),     64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("7xm3", 32'd7, 32'hFFFF_FFFD, lat, bsy, prod);
        check("7xm3_prod", prod, 64'hFFFF_FFFF_FFFF_FFEB);
        check("7xm3_lat",  64'(lat), 64'd33);
        check("7xm3_busy", 64'(bsy), 64'd33);

        // Back-to-back starts in the IDLE cycle after DONE; hold check covers previous result
        run_op("min_sq", 32'h8000_0000, 32'h8000_0000, lat, bsy, prod);
        check("min_sq_prod", prod, 64'h4000_0000_0000_0000);
        check("min_sq_lat",  64'(lat), 64'd33);

        run_op("max_sq", 32'h7FFF_FFFF, 32'h7FFF_FFFF, lat, bsy, prod);
        check("max_sq_prod", prod, 64'h3FFF_FFFF_0000_0001);

        run_op("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bsy, prod);
        check("m1xm1_prod", prod, 64'h0000_0000_0000_0001);

        run_op("m1xmin", 32'hFFFF_FFFF, 32'h8000_0000, lat, bsy, prod);
        check("m1xmin_prod", prod, 64'h0000_0000_8000_0000);

        run_op("zero_a", 32'd0, 32'd1234, lat, bsy, prod);
        check("zero_a_prod", prod, 64'd0);
        check("zero_a_lat",  64'(lat), 64'(ZERO_LAT));
        check("zero_a_busy", 64'(bsy), 64'(ZERO_BSY));

        run_op("zero_b", 32'hDEAD_BEEF, 32'd0, lat, bsy, prod);
        check("zero_b_prod", prod, 64'd0);
        check("zero_b_lat",  64'(lat), 64'(ZERO_LAT));

        // Start 5x6, then a second start and operand changes while busy
        u_if.a_in = 32'd5;
        u_if.b_in = 32'd6;
        u_if.mult_control = 1'b1;
        @(posedge clk); #1;
        u_if.mult_control = 1'b0;
        ends = 0;
        lat  = 0;
        prod = '0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 9) begin
                u_if.mult_control = 1'b1;
                u_if.a_in = 32'd9;
                u_if.b_in = 32'd9;
            end else begin
                u_if.mult_control = 1'b0;
                if (i == 10) begin
                    u_if.a_in = 32'd11;
                    u_if.b_in = 32'd13;
                end
            end
            @(posedge clk); #1;
            if (u_if.mult_end) begin
                ends++;
                if (ends == 1) begin
                    lat  = i + 1;
                    prod = {u_if.hi_out, u_if.lo_out};
                end
            end
        end
        check("ign_ends", 64'(ends), 64'd1);
        check("ign_lat",  64'(lat),  64'd33);
        check("ign_prod", prod, 64'd30);

        // Reset aborts a RUN in progress
        u_if.a_in = 32'd5;
        u_if.b_in = 32'd6;
        u_if.mult_control = 1'b1;
        @(posedge clk); #1;
        u_if.mult_control = 1'b0;
        ends = 0;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
            if (u_if.mult_end) ends++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_hi",   64'(u_if.hi_out),   64'd0);
        check("abort_lo",   64'(u_if.lo_out),   64'd0);
        check("abort_end",  64'(u_if.mult_end), 64'd0);
        check("abort_busy", 64'(u_if.busy),     64'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (u_if.mult_end) ends++;
        end
        check("abort_no_end", 64'(ends), 64'd0);

        run_op("3x4", 32'd3, 32'd4, lat, bsy, prod);
        check("3x4_prod", prod, 64'd12);
        check("3x4_lat",  64'(lat), 64'd33);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 by the package constant MULT_W.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 mult_control  input  1  start request from the control unit; single-cycle level.
REQ-005 a_in  input  32  multiplicand, two's complement (register A).
REQ-006 b_in  input  32  multiplier, two's complement (register B).
REQ-007 hi_out  output  32  upper product word, to HI register.
REQ-008 lo_out  output  32  lower product word, to LO register.
REQ-009 mult_end  output  1  one-cycle completion pulse back to the control unit.
REQ-010 busy  output  1  high while an operation is in progress.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE with mult_control=1, the block SHALL latch a_in and b_in, load the accumulator to 0 and Q to b_in, clear Q-1 and the 6-bit counter, and enter RUN on the next edge.
REQ-013 RUN SHALL perform one radix-2 Booth step per cycle for 32 cycles: on {Q[0],Q-1}=01 add M, on 10 subtract M, on 00/11 no operation, then arithmetic-shift {acc,Q,Q-1} right by 1.
REQ-014 The accumulator and M SHALL be 33 bits, sign-extended, so that the multiplicand 0x80000000 produces a correct result.
REQ-015 After step 32, the block SHALL enter DONE, drive hi_out={acc[31:0]} upper word and lo_out=Q, and assert mult_end for exactly that one cycle.
REQ-016 DONE SHALL always return to IDLE on the next edge.
REQ-017 Latency SHALL be fixed: start sampled at edge T, mult_end high during cycle T+33 (without the REQ-025 feature).
REQ-018 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-019 mult_control SHALL be ignored while busy=1; no restart and no queuing occurs.
REQ-020 hi_out and lo_out SHALL hold the last result until the next DONE; they SHALL NOT change during RUN.
REQ-021 Changes to a_in or b_in after the start edge SHALL NOT affect the result in progress.
REQ-022 The product SHALL be the exact signed 64-bit product; overflow cannot occur.

Reset
REQ-023 With reset=1 at an edge, the block SHALL go to IDLE, and hi_out, lo_out, mult_end, busy, the counter, the accumulator, Q, Q-1 and M SHALL all be 0.
REQ-024 Reset SHALL take priority over mult_control and SHALL abort a RUN mid-operation with no mult_end pulse.

Configuration
REQ-025 When MULT_EARLY_ZERO_EN is defined, a start with a_in==0 or b_in==0 SHALL go directly from IDLE to DONE with hi_out=lo_out=0, giving mult_end at T+1.
REQ-026 When MULT_EARLY_ZERO_EN is undefined, zero operands SHALL take the full 33-cycle path with an identical result.

Structure
REQ-027 The package mult_pkg SHALL hold MULT_W=32, MULT_STEPS=32, the state typedef (IDLE/RUN/DONE) and the Booth-op encoding (NOP/ADD/SUB).
REQ-028 The purely combinational Booth add/sub-and-shift step SHALL be the single sub-module booth_step; all registers SHALL stay in mult_unit.

Verification
REQ-029 a=7, b=-3, pulse start -> mult_end exactly 33 cycles later, HI=0xFFFFFFFF, LO=0xFFFFFFEB, busy high for 33 cycles.
REQ-030 a=0x80000000, b=0x80000000 -> HI=0x40000000, LO=0x00000000; also a=0x7FFFFFFF, b=0x7FFFFFFF -> HI=0x3FFFFFFF, LO=0x00000001.
REQ-031 Start with 5x6, then pulse start with 9x9 at cycle 10 while busy and change a_in/b_in -> single mult_end, result HI=0, LO=30.
REQ-032 Start 5x6, assert reset at cycle 15 -> no mult_end, all outputs 0 the next cycle, and a new start 3x4 completes with LO=12.
REQ-033 a=0, b=1234 -> HI=LO=0; mult_end at T+1 with MULT_EARLY_ZERO_EN defined, at T+33 without it.
REQ-034 Back-to-back: start again in the IDLE cycle right after DONE -> accepted; HI/LO hold the previous result until the new DONE.
